// File: rtl/uart_rx_controller.sv
// uart_rx_controller: 8N1 receive deframer with one-entry valid/ack holding register
module uart_rx_controller #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 framing_error,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_ST} state_t;
  state_t               state;
  logic                 sync_1;
  logic                 rx_sync;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bits;
  logic [DATA_BITS-1:0] shreg;
  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync_1  <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync_1  <= rx;
      rx_sync <= sync_1;
    end
  end
  // deframing FSM plus holding-register handshake; a completing frame overrides a same-cycle ack
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state         <= IDLE;
      cnt           <= '0;
      bits          <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_sync) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          cnt <= cnt + CW'(1);
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            bits  <= '0;
            state <= rx_sync ? IDLE : DATA;
            busy  <= !rx_sync;
          end
        end
        DATA: begin
          cnt <= cnt + CW'(1);
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= DATA_BITS'({rx_sync, shreg} >> 1);
            bits  <= bits + BW'(1);
            if (bits == DATA_LAST) state <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt + CW'(1);
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack) overrun <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              shreg         <= '0;
              state         <= BREAK_ST;
            end
          end
        end
        default: begin
          cnt <= cnt + CW'(1);
          if (rx_sync) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed and randomized frames checked against a holding-register model
module tb_uart_rx_controller;
  localparam int CPB = 16;
  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, framing_error, busy;
  int         cyc = 0;
  int         e0 = 0;
  int         fe_cnt = 0;
  int         errors = 0;
  int         checks = 0;
  logic       exp_valid = 1'b0;
  logic       exp_ovr = 1'b0;
  logic [7:0] exp_data = 8'h00;

  uart_rx_controller #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clock(clock), .reset_L(reset_L), .rx(rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .framing_error(framing_error), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (framing_error) fe_cnt <= fe_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // advance to the negedge following posedge n
  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // called at a negedge: drives start + 8 data bits LSB first, then the stop level; returns at e0+143
  task automatic start_frame(input logic [7:0] d, input logic stop_bit);
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
  endtask

  task automatic m_ack();
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr = 1'b0;
    end
  endtask

  task automatic m_frame(input logic [7:0] d, input logic ack_same);
    if (exp_valid) exp_ovr = !ack_same;
    exp_valid = 1'b1;
    exp_data = d;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, rx_valid, exp_valid);
    check({tag, "_data"}, rx_data, exp_data);
    check({tag, "_ovr"}, overrun, exp_ovr);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    m_ack();
  endtask

  initial begin
    int fe0;
    int n;
    int mode;
    logic [7:0] d;
    repeat (3) @(negedge clock);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ovr", overrun, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_L = 1'b1;
    repeat (3) @(negedge clock);

    fe0 = fe_cnt;
    fork
      start_frame(8'hA5, 1'b1);
      begin
        @(negedge clock);
        wait_until(e0 + 1);
        check("a5_busy_e1", busy, 1'b0);
        wait_until(e0 + 2);
        check("a5_busy_e2", busy, 1'b1);
      end
    join
    wait_until(e0 + 153);
    check("a5_valid_early", rx_valid, 1'b0);
    wait_until(e0 + 154);
    m_frame(8'hA5, 1'b0);
    check_model("a5");
    check("a5_busy_end", busy, 1'b0);
    check("a5_no_fe", fe_cnt - fe0, 0);
    ack_pulse();
    check("a5_ack_valid", rx_valid, 1'b0);
    wait_until(e0 + 159);
    rx = 1'b1;
    repeat (5) @(negedge clock);

    fe0 = fe_cnt;
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    wait_until(e0 + 2);
    check("gl_busy_e2", busy, 1'b1);
    wait_until(e0 + 9);
    check("gl_busy_e9", busy, 1'b1);
    wait_until(e0 + 10);
    check("gl_busy_e10", busy, 1'b0);
    repeat (20) @(negedge clock);
    check("gl_valid", rx_valid, 1'b0);
    check("gl_no_fe", fe_cnt - fe0, 0);

    fe0 = fe_cnt;
    start_frame(8'h3C, 1'b0);
    wait_until(e0 + 153);
    check("fe_before", framing_error, 1'b0);
    wait_until(e0 + 154);
    check("fe_pulse", framing_error, 1'b1);
    wait_until(e0 + 155);
    check("fe_after", framing_error, 1'b0);
    wait_until(e0 + 199);
    check("fe_break_busy", busy, 1'b1);
    check("fe_count", fe_cnt - fe0, 1);
    check("fe_valid", rx_valid, 1'b0);
    n = cyc + 1;
    rx = 1'b1;
    wait_until(n + 1);
    check("brk_still_busy", busy, 1'b1);
    wait_until(n + 2);
    check("brk_idle", busy, 1'b0);
    repeat (200) @(negedge clock);
    check("brk_no_frame", rx_valid, 1'b0);

    start_frame(8'h11, 1'b1);
    wait_until(e0 + 154);
    m_frame(8'h11, 1'b0);
    check_model("b2b1");
    wait_until(e0 + 159);
    start_frame(8'h22, 1'b1);
    wait_until(e0 + 154);
    m_frame(8'h22, 1'b0);
    check_model("b2b2");
    ack_pulse();
    check_model("b2b_ack");
    wait_until(e0 + 159);

    start_frame(8'h55, 1'b1);
    wait_until(e0 + 154);
    m_frame(8'h55, 1'b0);
    check_model("sa1");
    wait_until(e0 + 159);
    start_frame(8'h66, 1'b1);
    wait_until(e0 + 153);
    rx_ack = 1'b1;
    wait_until(e0 + 154);
    rx_ack = 1'b0;
    m_frame(8'h66, 1'b1);
    check_model("sa2");
    wait_until(e0 + 159);
    rx = 1'b1;

    e0 = cyc + 1;
    rx = 1'b0;
    wait_until(e0 + 15);
    rx = 1'b1;
    wait_until(e0 + 60);
    check("pre_rst_busy", busy, 1'b1);
    reset_L = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 1'b0);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    exp_valid = 1'b0;
    exp_ovr = 1'b0;
    exp_data = 8'h00;
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    repeat (20) @(negedge clock);
    check("post_rst_valid", rx_valid, 1'b0);
    start_frame(8'h81, 1'b1);
    wait_until(e0 + 154);
    m_frame(8'h81, 1'b0);
    check_model("r81");
    wait_until(e0 + 159);

    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      mode = $urandom_range(0, 2);
      start_frame(d, 1'b1);
      wait_until(e0 + 152);
      if (mode == 1) begin
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
        m_ack();
      end
      wait_until(e0 + 153);
      if (mode == 2) rx_ack = 1'b1;
      wait_until(e0 + 154);
      rx_ack = 1'b0;
      m_frame(d, mode == 2);
      check_model($sformatf("rnd%0d", k));
      wait_until(e0 + 159);
      rx = 1'b1;
      repeat ($urandom_range(0, 20)) @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side controller for the UART. It synchronizes the asynchronous serial line and sequences a mid-bit sampling counter, a bit counter and an LSB-first shift register to deframe 8N1 characters. Completed bytes go to a one-entry holding register with a valid/ack handshake toward the host-side logic. It is the receive counterpart of the transmit path and sits directly behind the rx pin.

## Interface
- CLKS_PER_BIT, 16, system clocks per serial bit; even, >= 4
- DATA_BITS, 8, data bits per frame; 1..8 meaningful, LSB first
- clock  input  1  system clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- rx  input  1  asynchronous serial line, idle high
- rx_ack  input  1  consumer accepts rx_data this cycle
- rx_data  output  DATA_BITS  holding register, last good character
- rx_valid  output  1  holding register full; held until acked
- overrun  output  1  sticky; a good frame overwrote unacked data
- framing_error  output  1  one-cycle pulse, stop bit sampled low
- busy  output  1  state != IDLE

## Operation
- rx passes through a two-flop synchronizer (both flops reset to 1) giving rx_sync; the FSM uses only rx_sync.
- Sample counter cnt, width $clog2(CLKS_PER_BIT): cleared on every state transition; otherwise increments each cycle outside IDLE. HALF = CLKS_PER_BIT/2.
- Bit counter bits, width $clog2(DATA_BITS+1): cleared on entry to DATA.
- States and transitions:
  - IDLE: rx_sync==0 -> START.
  - START: at cnt==HALF-1, rx_sync==0 -> DATA; rx_sync==1 -> IDLE (glitch rejected, no outputs).
  - DATA: at cnt==CLKS_PER_BIT-1, shift right: shreg <= {rx_sync, shreg[DATA_BITS-1:1]}, bits++; when this is bit DATA_BITS -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, rx_sync==1 -> load rx_data <= shreg, set rx_valid, -> IDLE; rx_sync==0 -> framing_error pulse, shreg discarded, -> BREAK.
  - BREAK: rx_sync==1 -> IDLE (prevents retriggering on a held-low line).
- Handshake: rx_valid clears at the edge where rx_ack==1 and rx_valid==1; rx_ack while rx_valid==0 is ignored. overrun clears on any accepted ack.
- Good frame completes while rx_valid==1 and rx_ack==0: rx_data overwritten, rx_valid stays 1, overrun set.
- Good frame completes in the same cycle rx_ack==1: new data loaded, rx_valid stays 1, overrun not set.
- Reset values: state IDLE, sync flops 1, cnt 0, bits 0, shreg 0, rx_data 0, rx_valid 0, overrun 0, framing_error 0, busy 0. reset_L assertion mid-frame abandons the frame immediately; no partial data reaches rx_data.

## Timing
- All state, counters and outputs are registered on rising clock; no combinational path from rx or rx_ack to any output.
- Synchronizer latency: 2 cycles. Let E0 be the edge where the first sync flop captures rx low.
- START entered at E0+2. Start bit is verified at E0+2+HALF. Data bit k (k=1..DATA_BITS) is sampled at E0+2+HALF+k*CLKS_PER_BIT. Stop bit is sampled at E0+2+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
- rx_valid/rx_data update, or the framing_error pulse, occurs at the stop-sample edge. With defaults this is E0+154.
- FSM returns to IDLE mid-stop-bit, so a following start bit is accepted with no idle gap.
- busy rises at E0+2 and falls at the stop-sample edge (good frame) or on leaving BREAK.

## Test plan
- Default params, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_valid rises at E0+154, rx_data==0xA5, overrun 0, framing_error never pulses; assert rx_ack one cycle -> rx_valid 0 next edge.
- Low glitch of 5 cycles on rx -> START entered, returns to IDLE at E0+10, rx_valid/framing_error stay 0.
- Frame 0x3C with stop bit low, then rx held low 40 cycles -> framing_error single-cycle pulse at E0+154, FSM in BREAK until rx_sync high, rx_valid stays 0, no new frame from the held-low line.
- Back-to-back 0x11 then 0x22 with no ack -> second completion sets overrun=1, rx_data==0x22; rx_ack clears rx_valid and overrun together.
- 0x55 then 0x66 with rx_ack pulsed exactly on the second stop-sample edge -> rx_data==0x66, rx_valid 1, overrun 0.
- reset_L pulsed low mid-DATA of 0xFF -> all outputs at reset values immediately; next clean 0x81 frame received correctly.
